// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin front end sharing one bit-serial Gray-to-binary converter.
// Grant edge -> ack in N+1 clocks (N CONV + 1 DONE); one IDLE cycle between grants.
module gray_conv_arbiter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic [N-1:0] g0,
   input  logic         req1,
   input  logic [N-1:0] g1,
   output logic         busy,
   output logic         grant,
   output logic         ack0,
   output logic         ack1,
   output logic [N-1:0] B
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t         state, state_nxt;
   logic [N-1:0]   g_lat;
   logic [N-1:0]   w;
   logic [N-1:0]   w_nxt;
   logic [CW-1:0]  cnt;
   logic           prev;
   logic           bit_nxt;
   logic           winner;

   // prev is cleared on the grant edge, so the MSB falls out as g[N-1] ^ 0.
   always_comb begin
      state_nxt = state;
      winner    = (req0 && req1) ? ~grant : req1;
      bit_nxt   = g_lat[cnt] ^ prev;
      w_nxt     = w;
      w_nxt[cnt] = bit_nxt;
      case (state)
         IDLE:    if (req0 || req1) state_nxt = CONV;
         CONV:    if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= 1'b1;
         B     <= '0;
         cnt   <= '0;
         g_lat <= '0;
         w     <= '0;
         prev  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  g_lat <= winner ? g1 : g0;
                  grant <= winner;
                  cnt   <= CW'(N-1);
                  prev  <= 1'b0;
                  w     <= '0;
               end
            end
            CONV: begin
               w    <= w_nxt;
               prev <= bit_nxt;
               if (cnt == '0) B <= w_nxt;
               else           cnt <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign ack0 = (state == DONE) && !grant;
   assign ack1 = (state == DONE) &&  grant;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: stimulus queues expected acks, a monitor checks them.
module tb_gray_conv_arbiter;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0 = 1'b0;
   logic         req1 = 1'b0;
   logic [N-1:0] g0 = '0;
   logic [N-1:0] g1 = '0;
   logic         busy, grant, ack0, ack1;
   logic [N-1:0] B;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic         id;
      logic [N-1:0] b;
      int           cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   logic [N-1:0] prev_b = '0;

   gray_conv_arbiter #(.N(N)) dut (
      .clk(clk), .rst(rst), .req0(req0), .g0(g0), .req1(req1), .g1(g1),
      .busy(busy), .grant(grant), .ack0(ack0), .ack1(ack1), .B(B)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [N-1:0] bin_of(input logic [N-1:0] g);
      logic acc;
      logic [N-1:0] r;
      acc = 1'b0;
      r = '0;
      for (int i = N - 1; i >= 0; i--) begin
         acc = acc ^ g[i];
         r[i] = acc;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every ack must match the oldest queued expectation, B frozen mid-conversion.
   always @(negedge clk) begin
      if (!rst) begin
         if (ack0 || ack1) begin
            chk("ack_onehot", {31'b0, ack0 & ack1}, 32'd0);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: ack0=%0b ack1=%0b B=%0h, required no ack", ack0, ack1, B);
            end else begin
               mon_e = q.pop_front();
               chk("ack_id", {31'b0, ack1}, {31'b0, mon_e.id});
               chk("ack_B", {24'b0, B}, {24'b0, mon_e.b});
               chk("ack_cycle", cyc, mon_e.cyc);
            end
         end else if (busy) begin
            chk("B_hold", {24'b0, B}, {24'b0, prev_b});
         end
      end
      prev_b = B;
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   // Called at a negedge in IDLE; grant happens on the next posedge.
   task automatic issue(input logic id, input logic [N-1:0] g, input logic [N-1:0] expb);
      exp_t e;
      if (id) begin req1 = 1'b1; g1 = g; end
      else    begin req0 = 1'b1; g0 = g; end
      e.id = id; e.b = expb; e.cyc = cyc + 1 + N;
      q.push_back(e);
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   initial begin
      int gcyc, n, j;
      logic [N-1:0] r;
      logic [N-1:0] tbl [16];
      logic [N-1:0] gv [4];
      exp_t e;
      tbl = '{8'd0, 8'd1, 8'd3, 8'd2, 8'd7, 8'd6, 8'd4, 8'd5,
              8'd15, 8'd14, 8'd12, 8'd13, 8'd8, 8'd9, 8'd11, 8'd10};
      gv = '{8'hA0, 8'h5A, 8'hC3, 8'h11};

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_grant", {31'b0, grant}, 32'd1);
      chk("rst_ack0", {31'b0, ack0}, 32'd0);
      chk("rst_ack1", {31'b0, ack1}, 32'd0);
      chk("rst_B", {24'b0, B}, 32'd0);
      rst = 1'b0;

      // Tie from reset: req0 first, req1 N+2 later
      @(negedge clk);
      req0 = 1'b1; req1 = 1'b1; g0 = 8'h80; g1 = 8'hFF;
      gcyc = cyc + 1;
      e.id = 1'b0; e.b = 8'hFF; e.cyc = gcyc + N;     q.push_back(e);
      e.id = 1'b1; e.b = 8'hAA; e.cyc = gcyc + 2*N + 2; q.push_back(e);
      @(negedge clk);
      req0 = 1'b0;
      n = 0;
      while (cyc < gcyc + N + 2 && n < 100) begin @(negedge clk); n++; end
      req1 = 1'b0;
      wait_idle();

      // Single request, busy duration
      req0 = 1'b1; g0 = 8'b0000_1111;
      e.id = 1'b0; e.b = 8'b0000_1010; e.cyc = cyc + 1 + N; q.push_back(e);
      n = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         req0 = 1'b0;
         if (busy) n++;
      end
      chk("busy_cycles", n, N + 1);

      // Sweep of small Gray words
      for (int v = 0; v < 16; v++) begin
         wait_idle();
         r = v[N-1:0];
         issue(1'b0, r, tbl[v]);
      end

      // Random words on alternating requesters
      for (int i = 0; i < 256; i++) begin
         wait_idle();
         r = $urandom;
         issue(i[0], r, bin_of(r));
      end

      // Abort in 3rd CONV cycle
      wait_idle();
      req0 = 1'b1; g0 = 8'h3C;
      @(negedge clk);
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_B", {24'b0, B}, 32'd0);
      chk("abort_ack", {30'b0, ack0, ack1}, 32'd0);
      chk("abort_grant", {31'b0, grant}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (N + 4) @(negedge clk);
      issue(1'b1, 8'h01, 8'h01);
      wait_idle();

      // Fairness with g0 changing mid-conversion
      req0 = 1'b1; req1 = 1'b1; g0 = gv[0]; g1 = 8'hB0;
      gcyc = cyc + 1;
      for (int k = 0; k < 6; k++) begin
         e.id = k[0];
         e.b = k[0] ? bin_of(8'hB0) : bin_of(gv[k/2]);
         e.cyc = gcyc + k*(N+2) + N;
         q.push_back(e);
      end
      j = 0;
      while (cyc < gcyc + 5*(N+2)) begin
         @(negedge clk);
         if ((cyc - gcyc) % (2*(N+2)) == 3) begin
            j++;
            g0 = gv[j];
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;

      n = 0;
      while (q.size() > 0 && n < 200) begin @(negedge clk); n++; end
      chk("queue_drain", q.size(), 32'd0);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
